result_uart_streamer: RTL and testbench
=======================================

Name: result_uart_streamer

Overview:
Downstream consumer of the single-core processor top level. It watches end_process and snapshots the sixteen 12-bit result registers (r1..r16) on its rising edge. It then serialises the snapshot as a framed UART 8N1 byte stream so a host PC can read the results without probing the FPGA.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
N_RES, 16, number of result words captured.
RES_W, 12, width of each result word; must be <= 16.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
end_process  input  1  processor completion flag, level; only a 0->1 transition triggers a capture.
results  input  N_RES*RES_W  flattened results; r1 in [RES_W-1:0], r16 in top slice.
tx  output  1  UART serial out, idle high.
busy  output  1  high from capture until the last stop bit completes.
done  output  1  one-cycle pulse after the final stop bit of a frame.

Behaviour:
- Reset (synchronous, active-high):
  - tx=1, busy=0, done=0.
  - FSM to IDLE; all counters to 0.
  - end_process_q to 1, so a level already high at reset release is NOT a trigger.
- Edge detect: trigger = end_process & ~end_process_q, evaluated every cycle.
- IDLE:
  - On trigger at edge k, results is copied into an internal bank at edge k.
  - busy=1 from edge k; FSM goes to SEND.
  - Start bit of byte 0 (tx=0) is driven from edge k+1.
- Frame content, 2*N_RES+1 bytes in this order:
  - Header byte 0xA5.
  - For i=1..N_RES: hi byte = zero-extended r_i[RES_W-1:8], then lo byte = r_i[7:0].
  - Default frame is 33 bytes.
- Byte format:
  - Start bit (0), 8 data bits LSB first, stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles, so one byte = 10*CLKS_PER_BIT cycles.
  - Bytes are back-to-back, with no idle gap between one stop bit and the next start bit.
- SEND sequencing: a byte index counter (0..2N_RES) selects the byte and advances when a byte's stop bit completes.
- Completion:
  - After the last byte's stop bit, FSM enters DONE for one cycle: done=1, busy=0 asserted at that edge, tx=1.
  - FSM then returns to IDLE.
  - Total time from trigger edge to done edge = 1 + 10*CLKS_PER_BIT*(2N_RES+1) cycles.
- Triggers while busy=1 or in DONE are ignored, not queued.
- The bank is frozen during SEND; changes on results after capture do not affect the stream.
- Reset mid-frame:
  - tx returns to 1 at that edge; the frame is abandoned, no done pulse.
  - A new frame requires a fresh 0->1 on end_process after reset.
- A new trigger may be accepted in the cycle after DONE; end_process must fall and rise again.

Decomposition:
- Package result_stream_pkg holds:
  - HEADER_BYTE = 8'hA5.
  - FSM state encoding {IDLE, SEND, DONE}.
  - Function frame_len(N_RES) = 2*N_RES+1.
- One natural sub-module: uart_tx_byte (CLKS_PER_BIT param).
  - Interface: load/data[7:0] in, tx/ready/byte_done out.
  - Owns the baud counter and bit counter.
  - The streamer owns the snapshot bank, byte mux, byte index counter and top FSM.

Test Plan:
Use CLKS_PER_BIT=4 in simulation for all scenarios.
- Basic frame: set r1=0x123, r2=0xFFF, r16=0x001, all others 0, then pulse end_process 0->1 → UART decoder sees A5 01 23 0F FF 00 00 … 00 01 (33 bytes), each bit 4 cycles. done pulses once exactly 1+1320 cycles after the trigger edge, and busy falls on the same edge.
- Snapshot isolation: after the trigger, change all results to 0xAAA mid-frame → the stream still carries the pre-trigger values.
- Retrigger while busy: toggle end_process 0->1->0->1 during byte 5 → only one 33-byte frame and one done pulse are produced.
- Level held high: hold end_process high from before reset release through 2000 cycles → no frame sent, tx stays 1, busy stays 0.
- Reset mid-frame: assert reset during byte 10's data bits → tx=1, busy=0 at the following edge, no done pulse. A subsequent 0->1 on end_process yields a complete, correct frame.
- Back-to-back frames: a second trigger 1 cycle after done → the second frame starts its start bit 1 cycle after that trigger and is byte-exact.

Source files
------------

// File: rtl/result_uart_streamer_pkg.sv
// Shared definitions for the result UART streamer: frame header, FSM
// encoding and frame length helper.
package result_stream_pkg;

    localparam logic [7:0]  HEADER_BYTE    = 8'hA5;
    localparam int unsigned BITS_PER_UBYTE = 10;   // start + 8 data + stop

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Header byte plus hi/lo byte per result word.
    function automatic int unsigned frame_len(input int unsigned n_res);
        return 2 * n_res + 1;
    endfunction

endpackage

// File: rtl/result_uart_streamer_if.sv
// Bundle between the processor side and the result streamer.
//   end_process : completion level from the processor
//   results     : flattened result words, r1 in the lowest slice
//   tx          : UART serial line, idle high
//   busy        : high while a frame is being captured/sent
//   done        : one-cycle pulse after the last stop bit
interface result_uart_streamer_if #(
    parameter int unsigned N_RES = 16,
    parameter int unsigned RES_W = 12
);
    logic                   end_process;
    logic [N_RES*RES_W-1:0] results;
    logic                   tx;
    logic                   busy;
    logic                   done;

    modport master (
        output end_process,
        output results,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  end_process,
        input  results,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/result_uart_streamer_uart_tx_byte.sv
// UART 8N1 byte transmitter with back-to-back capability.
//   clk, reset  : clock and synchronous active-high reset
//   load        : accept data when ready_c is high
//   data        : byte to send, LSB first
//   tx          : registered serial output, idle high
//   ready_c     : transmitter can accept a byte this cycle
//   byte_done_c : last cycle of the current stop bit
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready_c,
    output logic       byte_done_c
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic             active;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [8:0]       shreg;      // remaining data bits followed by the stop bit
    logic             bit_end_c;

    assign bit_end_c   = active && (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign byte_done_c = bit_end_c && (bit_cnt == 4'd9);
    // Accepting a load on the stop bit's final cycle keeps bytes gapless.
    assign ready_c     = !active || byte_done_c;

    // Baud/bit sequencing and serial shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx       <= 1'b1;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
        end else if (load && ready_c) begin
            tx       <= 1'b0;
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= {1'b1, data};
        end else if (active) begin
            if (bit_end_c) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/result_uart_streamer.sv
// Snapshots the processor result registers on a rising end_process and
// streams them as a framed UART byte sequence: header, then hi/lo bytes
// of r1..rN.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of result_uart_streamer_if
//                (end_process, results in; tx, busy, done out)
module result_uart_streamer
    import result_stream_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned N_RES        = 16,
    parameter int unsigned RES_W        = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    result_uart_streamer_if.slave  bus
);
    localparam int unsigned FRAME_LEN = frame_len(N_RES);
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN + 1);
    localparam int unsigned WORD_W    = (N_RES > 1) ? $clog2(N_RES) : 1;

    state_t             state_q, state_d;
    logic               end_process_q;
    logic               trigger_c;
    logic [RES_W-1:0]   bank [N_RES];
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;   // index of the next byte to load
    logic               load_c;
    logic [7:0]         byte_c;
    logic [WORD_W-1:0]  word_sel_c;
    logic [15:0]        word_ext_c;
    logic               uart_ready_c;
    logic               uart_byte_done_c;
    logic               uart_tx;

    assign trigger_c = bus.end_process & ~end_process_q;
    assign bus.tx    = uart_tx;

    // Byte mux: index 0 is the header, odd indices hi bytes, even indices lo bytes.
    always_comb begin
        word_sel_c = WORD_W'((byte_idx_q - IDX_W'(1)) >> 1);
        word_ext_c = 16'(bank[word_sel_c]);
        if (byte_idx_q == '0) begin
            byte_c = HEADER_BYTE;
        end else if (byte_idx_q[0]) begin
            byte_c = word_ext_c[15:8];
        end else begin
            byte_c = word_ext_c[7:0];
        end
    end

    // Next-state logic; triggers outside IDLE are dropped.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        load_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger_c) begin
                    state_d    = SEND;
                    byte_idx_d = '0;
                end
            end
            SEND: begin
                if (byte_idx_q < IDX_W'(FRAME_LEN)) begin
                    if (uart_ready_c) begin
                        load_c     = 1'b1;
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end else if (uart_byte_done_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, edge-detect history and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            byte_idx_q    <= '0;
            end_process_q <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            end_process_q <= bus.end_process;
            bus.busy      <= (state_d == SEND);
            bus.done      <= (state_d == DONE);
        end
    end

    // Snapshot bank, written only on an accepted trigger.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && trigger_c && !reset) begin
            for (int i = 0; i < int'(N_RES); i++) begin
                bank[i] <= bus.results[i*RES_W +: RES_W];
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk         (clk),
        .reset       (reset),
        .load        (load_c),
        .data        (byte_c),
        .tx          (uart_tx),
        .ready_c     (uart_ready_c),
        .byte_done_c (uart_byte_done_c)
    );

endmodule

// File: tb/tb_result_uart_streamer.sv
// Directed bench for result_uart_streamer with CLKS_PER_BIT=4.
module tb_result_uart_streamer;

    localparam int CPB       = 4;
    localparam int NR        = 16;
    localparam int RW        = 12;
    localparam int FRAME     = 33;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int DONE_AT   = 1 + BYTE_CYC * FRAME;   // 1321
    localparam int LOG_N     = 2700;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    result_uart_streamer_if #(.N_RES(NR), .RES_W(RW)) bus ();

    result_uart_streamer #(
        .CLKS_PER_BIT (CPB),
        .N_RES        (NR),
        .RES_W        (RW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       tx_log   [LOG_N];
    logic       busy_log [LOG_N];
    logic       done_log [LOG_N];
    logic [11:0] words     [NR];
    logic [7:0]  exp_bytes [FRAME];
    logic [7:0]  got_bytes [FRAME];
    bit          got_ok    [FRAME];

    task automatic apply_words();
        for (int i = 0; i < NR; i++) bus.results[i*RW +: RW] = words[i];
    endtask

    function automatic void build_expected();
        exp_bytes[0] = 8'hA5;
        for (int i = 0; i < NR; i++) begin
            exp_bytes[2*i+1] = {4'h0, words[i][11:8]};
            exp_bytes[2*i+2] = words[i][7:0];
        end
    endfunction

    // Decode a frame whose trigger edge is log index n0; each bit must be
    // stable for all CPB samples, start low and stop high.
    task automatic decode_frame(input int n0);
        for (int b = 0; b < FRAME; b++) begin
            int base;
            logic [7:0] val;
            bit ok;
            base = n0 + 1 + BYTE_CYC * b;
            val  = 8'h00;
            ok   = 1'b1;
            for (int j = 0; j < 10; j++) begin
                logic mid;
                mid = tx_log[base + CPB*j + 2];
                for (int s = 0; s < CPB; s++)
                    if (tx_log[base + CPB*j + s] !== mid) ok = 1'b0;
                if (j == 0 && mid !== 1'b0) ok = 1'b0;
                if (j == 9 && mid !== 1'b1) ok = 1'b0;
                if (j >= 1 && j <= 8) val[j-1] = mid;
            end
            got_bytes[b] = val;
            got_ok[b]    = ok;
        end
    endtask

    task automatic count_done(input int lo, input int hi, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int n = lo; n <= hi; n++) begin
            if (done_log[n] === 1'b1) begin
                if (cnt == 0) first = n;
                cnt++;
            end
        end
    endtask

    // Leaves the clock just after the trigger edge.
    task automatic fire();
        @(negedge clk);
        bus.end_process = 1'b0;
        @(negedge clk);
        bus.end_process = 1'b1;
        @(posedge clk);
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log[i]   = bus.tx;
            busy_log[i] = bus.busy;
            done_log[i] = bus.done;
        end
    endtask

    task automatic test_reset();
        bus.end_process = 1'b0;
        bus.results     = '0;
        reset           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL reset_idle: tx=%b busy=%b want tx=1 busy=0", bus.tx, bus.busy); end
    endtask

    task automatic test_basic_frame();
        int cnt, first, bad;
        for (int i = 0; i < NR; i++) words[i] = 12'h000;
        words[0]  = 12'h123;
        words[1]  = 12'hFFF;
        words[15] = 12'h001;
        apply_words();
        build_expected();
        fire();
        record(DONE_AT + 9);
        decode_frame(0);
        for (int b = 0; b < FRAME; b++) begin
            checks++;
            if (!got_ok[b] || got_bytes[b] !== exp_bytes[b]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h framing=%0d want %h", b, got_bytes[b], got_ok[b], exp_bytes[b]);
            end
        end
        // Hand-written spot checks of the documented stream A5 01 23 0F FF ... 00 01.
        checks++; if (got_bytes[1] !== 8'h01 || got_bytes[2] !== 8'h23 || got_bytes[3] !== 8'h0F || got_bytes[4] !== 8'hFF || got_bytes[32] !== 8'h01)
            begin errors++; $display("FAIL basic_spot: got %h %h %h %h %h want 01 23 0f ff 01", got_bytes[1], got_bytes[2], got_bytes[3], got_bytes[4], got_bytes[32]); end
        checks++; if (tx_log[0] !== 1'b1) begin errors++; $display("FAIL basic_trigger_edge_tx: got %b want 1", tx_log[0]); end
        count_done(0, DONE_AT + 8, cnt, first);
        checks++; if (cnt != 1 || first != DONE_AT)
            begin errors++; $display("FAIL basic_done: count=%0d at=%0d want count=1 at=%0d", cnt, first, DONE_AT); end
        bad = 0;
        for (int n = 0; n < DONE_AT; n++) if (busy_log[n] !== 1'b1) bad++;
        if (busy_log[DONE_AT] !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_busy: %0d wrong cycles want 0", bad); end
        checks++; if (tx_log[DONE_AT] !== 1'b1) begin errors++; $display("FAIL basic_done_tx: got %b want 1", tx_log[DONE_AT]); end
    endtask

    task automatic test_snapshot();
        int bad;
        for (int i = 0; i < NR; i++) words[i] = RW'(i * 499 + 124);
        apply_words();
        build_expected();
        fire();
        fork
            record(DONE_AT + 9);
            begin
                repeat (200) @(negedge clk);
                for (int i = 0; i < NR; i++) bus.results[i*RW +: RW] = 12'hAAA;
            end
        join
        decode_frame(0);
        bad = 0;
        for (int b = 0; b < FRAME; b++) if (!got_ok[b] || got_bytes[b] !== exp_bytes[b]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL snapshot_frame: %0d bad bytes want 0 (byte20 got %h want %h)", bad, got_bytes[20], exp_bytes[20]); end
    endtask

    task automatic test_retrigger();
        int cnt, first, bad;
        for (int i = 0; i < NR; i++) words[i] = RW'(12'hF00 - i * 37);
        apply_words();
        build_expected();
        fire();
        fork
            record(1500);
            begin
                repeat (205) @(negedge clk);
                bus.end_process = 1'b0;
                repeat (8) @(negedge clk);
                bus.end_process = 1'b1;
            end
        join
        decode_frame(0);
        bad = 0;
        for (int b = 0; b < FRAME; b++) if (!got_ok[b] || got_bytes[b] !== exp_bytes[b]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL retrigger_frame: %0d bad bytes want 0", bad); end
        count_done(0, 1499, cnt, first);
        checks++; if (cnt != 1 || first != DONE_AT)
            begin errors++; $display("FAIL retrigger_done: count=%0d at=%0d want count=1 at=%0d", cnt, first, DONE_AT); end
        bad = 0;
        for (int n = DONE_AT + 1; n < 1500; n++) if (tx_log[n] !== 1'b1 || busy_log[n] !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL retrigger_idle_after: %0d active cycles want 0", bad); end
    endtask

    task automatic test_level_high();
        int bad_tx, bad_busy, cnt, first;
        @(negedge clk);
        reset           = 1'b1;
        bus.end_process = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        record(2000);
        bad_tx = 0; bad_busy = 0;
        for (int n = 0; n < 2000; n++) begin
            if (tx_log[n] !== 1'b1) bad_tx++;
            if (busy_log[n] !== 1'b0) bad_busy++;
        end
        count_done(0, 1999, cnt, first);
        checks++; if (bad_tx != 0)   begin errors++; $display("FAIL level_tx: %0d low cycles want 0", bad_tx); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL level_busy: %0d busy cycles want 0", bad_busy); end
        checks++; if (cnt != 0)      begin errors++; $display("FAIL level_done: %0d pulses want 0", cnt); end
        bus.end_process = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int cnt, first, bad;
        for (int i = 0; i < NR; i++) words[i] = RW'((i * 273) ^ 12'h5A5);
        apply_words();
        build_expected();
        fire();
        // Reset seen at log index 410, inside byte 10's data bits.
        fork
            record(DONE_AT + 9);
            begin
                repeat (410) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        decode_frame(0);
        bad = 0;
        for (int b = 0; b < 10; b++) if (!got_ok[b] || got_bytes[b] !== exp_bytes[b]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_prefix: %0d bad bytes want 0", bad); end
        checks++; if (tx_log[410] !== 1'b1 || busy_log[410] !== 1'b0)
            begin errors++; $display("FAIL rstmid_edge: tx=%b busy=%b want tx=1 busy=0", tx_log[410], busy_log[410]); end
        bad = 0;
        for (int n = 410; n < DONE_AT + 9; n++) if (tx_log[n] !== 1'b1 || busy_log[n] !== 1'b0) bad++;
        count_done(0, DONE_AT + 8, cnt, first);
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d active cycles want 0", bad); end
        checks++; if (cnt != 0) begin errors++; $display("FAIL rstmid_done: %0d pulses want 0", cnt); end

        for (int i = 0; i < NR; i++) words[i] = RW'(i * 256 + 15 - i);
        apply_words();
        build_expected();
        fire();
        record(DONE_AT + 9);
        decode_frame(0);
        bad = 0;
        for (int b = 0; b < FRAME; b++) if (!got_ok[b] || got_bytes[b] !== exp_bytes[b]) bad++;
        count_done(0, DONE_AT + 8, cnt, first);
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_refire_frame: %0d bad bytes want 0", bad); end
        checks++; if (cnt != 1 || first != DONE_AT)
            begin errors++; $display("FAIL rstmid_refire_done: count=%0d at=%0d want count=1 at=%0d", cnt, first, DONE_AT); end
    endtask

    task automatic test_back_to_back();
        int cnt, first, bad;
        int n1;
        n1 = DONE_AT + 2;   // second trigger edge, one cycle after the DONE cycle
        for (int i = 0; i < NR; i++) words[i] = RW'(12'h0C3 + i * 211);
        apply_words();
        build_expected();
        fire();
        fork
            record(n1 + DONE_AT + 9);
            begin
                repeat (50) @(negedge clk);
                for (int i = 0; i < NR; i++) bus.results[i*RW +: RW] = RW'(12'h800 + i * 7);
                bus.end_process = 1'b0;
                repeat (n1 - 50) @(negedge clk);
                bus.end_process = 1'b1;
            end
        join
        decode_frame(0);
        bad = 0;
        for (int b = 0; b < FRAME; b++) if (!got_ok[b] || got_bytes[b] !== exp_bytes[b]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame1: %0d bad bytes want 0", bad); end

        for (int i = 0; i < NR; i++) words[i] = RW'(12'h800 + i * 7);
        build_expected();
        checks++; if (tx_log[n1] !== 1'b1 || tx_log[n1 + 1] !== 1'b0)
            begin errors++; $display("FAIL b2b_start: tx@trig=%b tx@trig+1=%b want 1 0", tx_log[n1], tx_log[n1 + 1]); end
        decode_frame(n1);
        bad = 0;
        for (int b = 0; b < FRAME; b++) if (!got_ok[b] || got_bytes[b] !== exp_bytes[b]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame2: %0d bad bytes want 0 (byte1 got %h want %h)", bad, got_bytes[1], exp_bytes[1]); end
        count_done(0, n1 + DONE_AT + 8, cnt, first);
        checks++; if (cnt != 2 || first != DONE_AT || done_log[n1 + DONE_AT] !== 1'b1)
            begin errors++; $display("FAIL b2b_done: count=%0d first=%0d second=%b want count=2 first=%0d second=1", cnt, first, done_log[n1 + DONE_AT], DONE_AT); end
        bus.end_process = 1'b0;
    endtask

    initial begin
        bus.end_process = 1'b0;
        bus.results     = '0;
        test_reset();
        test_basic_frame();
        test_snapshot();
        test_retrigger();
        test_level_high();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
